frog_hop_ctrl: RTL and testbench
================================

Name: frog_hop_ctrl

Overview:
Player-sprite controller for the Frogger-style game. It replaces continuous held-button motion with discrete tile hops: one debounced press produces exactly one hop of c_STEP pixels, animated one pixel per c_TICKS_PER_PIXEL clocks. It also tracks facing direction, supports respawn, and outputs a 1-cycle-latency draw bit from a rotatable sprite bitmap. It sits between the button synchronisers and the pixel mux, beside the obstacle/lane controllers.

Parameters:
c_SPRITE_SIZE, 32, sprite width = height in pixels (power of 2, 8..32)
c_STEP, 32, pixels travelled per hop (1..c_SPRITE_SIZE*2)
c_TICKS_PER_PIXEL, 25000, clock cycles per 1-pixel move during a hop (>=2)
c_COOLDOWN, 250000, idle cycles enforced after each hop before the next press is accepted
c_GAME_WIDTH, 640, playfield width in pixels
c_GAME_HEIGHT, 480, playfield height in pixels
c_START_X, (c_GAME_WIDTH-c_SPRITE_SIZE)/2, spawn column
c_START_Y, c_GAME_HEIGHT-c_SPRITE_SIZE, spawn row

Ports:
i_Clk  in  1  system clock
i_Rst_L  in  1  reset, asynchronous, active-low
i_Enable  in  1  1 = run; 0 = freeze all counters and position (pause)
i_Up / i_Dn / i_Lt / i_Rt  in  1 each  raw button levels, asynchronous
i_Respawn  in  1  1-cycle pulse from collision logic: return to spawn
i_Col_Count_Div  in  10  current pixel column
i_Row_Count_Div  in  10  current pixel row
o_Sprite_X  out  10  sprite top-left column
o_Sprite_Y  out  10  sprite top-left row
o_Facing  out  2  0=up 1=down 2=left 3=right
o_Busy  out  1  high in HOP or COOLDOWN
o_Hop_Done  out  1  1-cycle pulse when a hop completes
o_Draw_Sprite  out  1  sprite pixel at current count, registered

Behaviour:
- Reset (async assert, sync release): X=c_START_X, Y=c_START_Y, Facing=0, FSM=IDLE, all counters 0, o_Busy=0, o_Hop_Done=0, o_Draw_Sprite=0, synchroniser and edge flops 0.
- Each button passes through 2 flops, then a rising-edge detect on the synchronised level. Total latency raw edge -> press pulse: 3 clocks.
- Valid press: exactly one of the four press pulses is high in a cycle. Two or more coincident presses are ignored entirely.
- FSM IDLE: on a valid press with i_Enable=1, update o_Facing to the pressed direction. If target = pos +/- c_STEP lies within [0, GAME-SPRITE] on that axis, latch the direction, clear the tick/pixel counters and go to HOP. Otherwise stay IDLE with the facing updated and no movement. Bounds use 11-bit arithmetic so 0 - c_STEP does not wrap.
- HOP: the tick counter counts 0..c_TICKS_PER_PIXEL-1. At terminal count, move the position by 1 pixel in the latched direction and increment the pixel counter. After the c_STEP-th pixel, pulse o_Hop_Done in the same cycle as the final move and go to COOLDOWN. Presses during HOP are dropped, not queued.
- COOLDOWN: count c_COOLDOWN cycles, then go to IDLE. Presses are dropped.
- Hop duration is exactly c_STEP*c_TICKS_PER_PIXEL enabled cycles.
- i_Enable=0: hold the state, counters and position. Press pulses are discarded, but the edge-detect registers still track, so a button held through the unpause does not fire.
- i_Respawn: highest priority in any state, including mid-hop. Next cycle: X/Y = start, Facing=0, FSM=IDLE, counters cleared, no o_Hop_Done.
- Draw: the in-box test is col in [X, X+SIZE) and row in [Y, Y+SIZE), computed in 11 bits. Local (r,c) maps by facing: up (r,c); down (SIZE-1-r, c); left (c, r); right (c, SIZE-1-r). o_Draw_Sprite is registered with 1-cycle latency and is 0 outside the box. Position updates take effect immediately for the following pixel.

Decomposition:
- Shared package frog_game_pkg holds:
  - direction encoding constants DIR_UP/DN/LT/RT
  - FSM state encodings
  - game width/height defaults
- Sub-module frog_sprite_rom: input row index, output c_SPRITE_SIZE-bit row, combinational, bitmap initialised in the ROM. The orientation mux stays in frog_hop_ctrl.

Test Plan:
Sim parameters: SIZE=8, STEP=8, TICKS=4, COOLDOWN=10, 64x48 field, start (28,40).
- Reset then one Up press -> o_Busy rises 4 clocks after the raw edge; Y steps 40->32 one pixel every 4 clocks; o_Hop_Done pulses once at Y=32; o_Busy falls 10 clocks later.
- Down press at start Y=40 -> no move (target 48 > 40); o_Facing=1; o_Busy stays 0.
- Held Up for 200 cycles -> exactly one hop; second press during HOP/COOLDOWN -> ignored, Y ends at 32.
- Up and Lt rising on the same cycle -> no movement, facing unchanged; Lt alone at X=4 -> no move; Lt at X=8 -> X ends at 0.
- i_Respawn mid-hop at Y=35 -> next cycle (28,40), Facing=0, IDLE, no o_Hop_Done; i_Enable=0 for 50 cycles mid-hop -> position frozen, hop resumes and totals 32 enabled cycles.
- Raster scan over the sprite with Facing=3 -> o_Draw_Sprite equals the ROM bitmap rotated right, 1 cycle late; 0 at col=X+8 and row=Y-1.

Source files
------------

// File: rtl/frog_game_pkg.sv
// Shared encodings for the Frogger-style game blocks: directions, hop FSM states
// and default playfield dimensions.
package frog_game_pkg;

  localparam logic [1:0] DIR_UP = 2'd0;
  localparam logic [1:0] DIR_DN = 2'd1;
  localparam logic [1:0] DIR_LT = 2'd2;
  localparam logic [1:0] DIR_RT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOP      = 2'd1,
    ST_COOLDOWN = 2'd2
  } hop_state_t;

  localparam int GAME_WIDTH_DEF  = 640;
  localparam int GAME_HEIGHT_DEF = 480;

endpackage

// File: rtl/frog_sprite_rom.sv
// Frog sprite bitmap: an 8x8 base image scaled up to c_SPRITE_SIZE by pixel
// replication. Bit c of row_bits is column c of the selected row.
module frog_sprite_rom
  import frog_game_pkg::*;
#(
  parameter int c_SPRITE_SIZE = 32
) (
  input  logic [$clog2(c_SPRITE_SIZE)-1:0] row_idx,
  output logic [c_SPRITE_SIZE-1:0]         row_bits
);

  localparam int SCALE = c_SPRITE_SIZE / 8;

  logic [2:0] base_idx_s;
  logic [7:0] base_row_s;

  // Base-image row lookup; deliberately asymmetric so every orientation differs
  always_comb begin
    base_idx_s = 3'(int'(row_idx) / SCALE);
    case (base_idx_s)
      3'd0:    base_row_s = 8'b0100_0110;
      3'd1:    base_row_s = 8'b0111_1110;
      3'd2:    base_row_s = 8'b1101_1001;
      3'd3:    base_row_s = 8'b0111_1110;
      3'd4:    base_row_s = 8'b0011_1100;
      3'd5:    base_row_s = 8'b0111_1111;
      3'd6:    base_row_s = 8'b1100_0011;
      3'd7:    base_row_s = 8'b1000_0001;
      default: base_row_s = 8'b0000_0000;
    endcase
  end

  for (genvar g = 0; g < c_SPRITE_SIZE; g++) begin : g_col
    assign row_bits[g] = base_row_s[g / SCALE];
  end

endmodule

// File: rtl/frog_hop_ctrl.sv
// Player sprite controller: debounced button presses become discrete tile hops,
// with facing tracking, respawn and a registered sprite draw bit.
module frog_hop_ctrl
  import frog_game_pkg::*;
#(
  parameter int c_SPRITE_SIZE     = 32,
  parameter int c_STEP            = 32,
  parameter int c_TICKS_PER_PIXEL = 25000,
  parameter int c_COOLDOWN        = 250000,
  parameter int c_GAME_WIDTH      = GAME_WIDTH_DEF,
  parameter int c_GAME_HEIGHT     = GAME_HEIGHT_DEF,
  parameter int c_START_X         = (c_GAME_WIDTH - c_SPRITE_SIZE) / 2,
  parameter int c_START_Y         = c_GAME_HEIGHT - c_SPRITE_SIZE
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Enable,
  input  logic       i_Up,
  input  logic       i_Dn,
  input  logic       i_Lt,
  input  logic       i_Rt,
  input  logic       i_Respawn,
  input  logic [9:0] i_Col_Count_Div,
  input  logic [9:0] i_Row_Count_Div,
  output logic [9:0] o_Sprite_X,
  output logic [9:0] o_Sprite_Y,
  output logic [1:0] o_Facing,
  output logic       o_Busy,
  output logic       o_Hop_Done,
  output logic       o_Draw_Sprite
);

  localparam int SW = $clog2(c_SPRITE_SIZE);
  localparam int TW = $clog2(c_TICKS_PER_PIXEL);
  localparam int PW = $clog2(c_STEP + 1);
  localparam int CW = (c_COOLDOWN > 1) ? $clog2(c_COOLDOWN) : 1;

  localparam logic [9:0]    START_X  = 10'(c_START_X);
  localparam logic [9:0]    START_Y  = 10'(c_START_Y);
  localparam logic [10:0]   STEP_W   = 11'(c_STEP);
  localparam logic [10:0]   SIZE_W   = 11'(c_SPRITE_SIZE);
  localparam logic [10:0]   MAX_X_W  = 11'(c_GAME_WIDTH - c_SPRITE_SIZE);
  localparam logic [10:0]   MAX_Y_W  = 11'(c_GAME_HEIGHT - c_SPRITE_SIZE);
  localparam logic [SW-1:0] LOC_MAX  = SW'(c_SPRITE_SIZE - 1);

  // Button vector indexed by direction code
  logic [3:0] btn_raw_s;
  logic [3:0] sync1_r, sync2_r, prev_r, press_r;
  logic [3:0] rise_s;

  assign btn_raw_s = {i_Rt, i_Lt, i_Dn, i_Up};
  assign rise_s    = sync2_r & ~prev_r;

  // Synchronisers and edge detect keep tracking while paused; only the press is gated
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
      prev_r  <= 4'b0000;
      press_r <= 4'b0000;
    end else begin
      sync1_r <= btn_raw_s;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      press_r <= i_Enable ? rise_s : 4'b0000;
    end
  end

  logic       press_valid_s;
  logic [1:0] press_dir_s;

  // Accept only a lone press; coincident presses are dropped as a group
  always_comb begin
    press_valid_s = 1'b0;
    press_dir_s   = DIR_UP;
    case (press_r)
      4'b0001: begin press_valid_s = 1'b1; press_dir_s = DIR_UP; end
      4'b0010: begin press_valid_s = 1'b1; press_dir_s = DIR_DN; end
      4'b0100: begin press_valid_s = 1'b1; press_dir_s = DIR_LT; end
      4'b1000: begin press_valid_s = 1'b1; press_dir_s = DIR_RT; end
      default: begin press_valid_s = 1'b0; press_dir_s = DIR_UP; end
    endcase
  end

  hop_state_t  state_r;
  logic [9:0]  pos_x_r, pos_y_r;
  logic [1:0]  facing_r, hop_dir_r;
  logic [TW-1:0] tick_r;
  logic [PW-1:0] pix_r;
  logic [CW-1:0] cd_r;
  logic        busy_r, hop_done_r;

  logic [10:0] x_ext_s, y_ext_s, tgt_s, max_s;
  logic        in_bounds_s;

  assign x_ext_s = {1'b0, pos_x_r};
  assign y_ext_s = {1'b0, pos_y_r};

  // 11-bit target: a negative result sets bit 10 instead of wrapping into range
  always_comb begin
    tgt_s = 11'd0;
    max_s = 11'd0;
    case (press_dir_s)
      DIR_UP:  begin tgt_s = y_ext_s - STEP_W; max_s = MAX_Y_W; end
      DIR_DN:  begin tgt_s = y_ext_s + STEP_W; max_s = MAX_Y_W; end
      DIR_LT:  begin tgt_s = x_ext_s - STEP_W; max_s = MAX_X_W; end
      DIR_RT:  begin tgt_s = x_ext_s + STEP_W; max_s = MAX_X_W; end
      default: begin tgt_s = 11'd0;            max_s = 11'd0;   end
    endcase
    in_bounds_s = !tgt_s[10] && (tgt_s <= max_s);
  end

  // Hop FSM; respawn overrides everything, pause freezes all state
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_r    <= ST_IDLE;
      pos_x_r    <= START_X;
      pos_y_r    <= START_Y;
      facing_r   <= DIR_UP;
      hop_dir_r  <= DIR_UP;
      tick_r     <= '0;
      pix_r      <= '0;
      cd_r       <= '0;
      busy_r     <= 1'b0;
      hop_done_r <= 1'b0;
    end else if (i_Respawn) begin
      state_r    <= ST_IDLE;
      pos_x_r    <= START_X;
      pos_y_r    <= START_Y;
      facing_r   <= DIR_UP;
      hop_dir_r  <= DIR_UP;
      tick_r     <= '0;
      pix_r      <= '0;
      cd_r       <= '0;
      busy_r     <= 1'b0;
      hop_done_r <= 1'b0;
    end else begin
      hop_done_r <= 1'b0;
      if (i_Enable) begin
        case (state_r)
          ST_IDLE: begin
            if (press_valid_s) begin
              facing_r <= press_dir_s;
              if (in_bounds_s) begin
                hop_dir_r <= press_dir_s;
                tick_r    <= '0;
                pix_r     <= '0;
                busy_r    <= 1'b1;
                state_r   <= ST_HOP;
              end
            end
          end
          ST_HOP: begin
            if (tick_r == TW'(c_TICKS_PER_PIXEL - 1)) begin
              tick_r <= '0;
              pix_r  <= pix_r + PW'(1);
              case (hop_dir_r)
                DIR_UP:  pos_y_r <= pos_y_r - 10'd1;
                DIR_DN:  pos_y_r <= pos_y_r + 10'd1;
                DIR_LT:  pos_x_r <= pos_x_r - 10'd1;
                DIR_RT:  pos_x_r <= pos_x_r + 10'd1;
                default: pos_x_r <= pos_x_r;
              endcase
              if (pix_r == PW'(c_STEP - 1)) begin
                hop_done_r <= 1'b1;
                cd_r       <= '0;
                state_r    <= ST_COOLDOWN;
              end
            end else begin
              tick_r <= tick_r + TW'(1);
            end
          end
          ST_COOLDOWN: begin
            if (cd_r == CW'(c_COOLDOWN - 1)) begin
              cd_r    <= '0;
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              cd_r <= cd_r + CW'(1);
            end
          end
          default: begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  logic [10:0]     col_ext_s, row_ext_s;
  logic            in_box_s;
  logic [SW-1:0]   loc_r_s, loc_c_s, rom_row_s, rom_col_s;
  logic [c_SPRITE_SIZE-1:0] rom_bits_s;
  logic            draw_r;

  assign col_ext_s = {1'b0, i_Col_Count_Div};
  assign row_ext_s = {1'b0, i_Row_Count_Div};

  frog_sprite_rom #(.c_SPRITE_SIZE(c_SPRITE_SIZE)) u_rom (
    .row_idx  (rom_row_s),
    .row_bits (rom_bits_s)
  );

  // Box test plus orientation of local coordinates into ROM row/column
  always_comb begin
    in_box_s = (col_ext_s >= x_ext_s) && (col_ext_s < x_ext_s + SIZE_W) &&
               (row_ext_s >= y_ext_s) && (row_ext_s < y_ext_s + SIZE_W);
    loc_c_s  = SW'(i_Col_Count_Div - pos_x_r);
    loc_r_s  = SW'(i_Row_Count_Div - pos_y_r);
    case (facing_r)
      DIR_UP:  begin rom_row_s = loc_r_s;           rom_col_s = loc_c_s;           end
      DIR_DN:  begin rom_row_s = LOC_MAX - loc_r_s; rom_col_s = loc_c_s;           end
      DIR_LT:  begin rom_row_s = loc_c_s;           rom_col_s = loc_r_s;           end
      DIR_RT:  begin rom_row_s = loc_c_s;           rom_col_s = LOC_MAX - loc_r_s; end
      default: begin rom_row_s = loc_r_s;           rom_col_s = loc_c_s;           end
    endcase
  end

  // Registered draw bit, one pixel of latency
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      draw_r <= 1'b0;
    end else begin
      draw_r <= in_box_s & rom_bits_s[rom_col_s];
    end
  end

  assign o_Sprite_X    = pos_x_r;
  assign o_Sprite_Y    = pos_y_r;
  assign o_Facing      = facing_r;
  assign o_Busy        = busy_r;
  assign o_Hop_Done    = hop_done_r;
  assign o_Draw_Sprite = draw_r;

endmodule

// File: tb/tb_frog_hop_ctrl.sv
// Self-checking bench for frog_hop_ctrl: directed and random presses checked
// cycle by cycle against an arithmetic timeline model, plus raster draw checks.
module tb_frog_hop_ctrl;

  localparam int SZ = 8, STEP = 8, TK = 4, CD = 10, GW = 64, GH = 48;
  localparam int SX = 28, SY = 40;
  localparam int LAT = 4;                       // raw edge to hop start
  localparam int HOP_END = LAT + STEP * TK;     // edge of the final move
  localparam int IDLE_AT = HOP_END + CD;        // edge where busy drops

  logic clk = 1'b0;
  logic rst_l, en, up, dn, lt, rt, resp;
  logic [9:0] col, row;
  logic [9:0] sx, sy;
  logic [1:0] fac;
  logic busy, done, draw;
  logic [3:0] btn_v;

  int total = 0, bad = 0;
  int mx, my, mf;
  logic [7:0] bmp [8];

  always #5 clk = ~clk;

  frog_hop_ctrl #(
    .c_SPRITE_SIZE(SZ), .c_STEP(STEP), .c_TICKS_PER_PIXEL(TK), .c_COOLDOWN(CD),
    .c_GAME_WIDTH(GW), .c_GAME_HEIGHT(GH)
  ) dut (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_Enable(en),
    .i_Up(up), .i_Dn(dn), .i_Lt(lt), .i_Rt(rt), .i_Respawn(resp),
    .i_Col_Count_Div(col), .i_Row_Count_Div(row),
    .o_Sprite_X(sx), .o_Sprite_Y(sy), .o_Facing(fac),
    .o_Busy(busy), .o_Hop_Done(done), .o_Draw_Sprite(draw)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_btn();
    {rt, lt, dn, up} = btn_v;
  endtask

  // One press episode; mode 0 plain, 1 extra press while busy, 2 pause, 3 respawn
  task automatic run_press(input logic [3:0] mask, input int hold, input int mode, input int p_len);
    int single, d, valid, tx, ty, s_at, s_dir, p_at, r_at, n, e, k, en_edge;
    int ex, ey, ef, eb, eh;
    single = ($countones(mask) == 1);
    d = mask[0] ? 0 : mask[1] ? 1 : mask[2] ? 2 : 3;
    tx = mx; ty = my;
    case (d)
      0: ty = my - STEP;
      1: ty = my + STEP;
      2: tx = mx - STEP;
      default: tx = mx + STEP;
    endcase
    valid = single && tx >= 0 && tx <= GW - SZ && ty >= 0 && ty <= GH - SZ;
    if (!valid && mode == 1) mode = 0;
    if (mode != 2) p_len = 0;
    s_at  = $urandom_range(LAT, IDLE_AT - 8);
    s_dir = (d + 1 + $urandom_range(0, 2)) % 4;
    p_at  = $urandom_range(LAT, HOP_END + 4);
    r_at  = $urandom_range(LAT + 1, HOP_END - 1);
    n = IDLE_AT + hold + p_len + 6;
    btn_v = mask; drive_btn();
    e = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      en_edge = en;
      e += en_edge;
      if (mode == 3 && i >= r_at + 1) begin
        ex = SX; ey = SY; ef = 0; eb = 0; eh = 0;
      end else begin
        ef = (single && e >= LAT) ? d : mf;
        k = 0;
        if (valid && e >= LAT) begin
          k = (e - LAT) / TK;
          if (k > STEP) k = STEP;
        end
        ex = mx + ((d == 2) ? -k : (d == 3) ? k : 0);
        ey = my + ((d == 0) ? -k : (d == 1) ? k : 0);
        eb = (valid && e >= LAT && e < IDLE_AT) ? 1 : 0;
        eh = (valid && en_edge && e == HOP_END) ? 1 : 0;
      end
      chk($sformatf("x@%0d", i), sx, ex);
      chk($sformatf("y@%0d", i), sy, ey);
      chk($sformatf("facing@%0d", i), fac, ef);
      chk($sformatf("busy@%0d", i), busy, eb);
      chk($sformatf("hop_done@%0d", i), done, eh);
      if (i == hold) btn_v = btn_v & ~mask;
      if (mode == 1 && i == s_at) btn_v[s_dir] = 1'b1;
      if (mode == 1 && i == s_at + 2) btn_v[s_dir] = 1'b0;
      drive_btn();
      if (mode == 2 && i == p_at) en = 1'b0;
      if (mode == 2 && i == p_at + p_len) en = 1'b1;
      if (mode == 3) resp = (i == r_at);
    end
    if (mode == 3) begin
      mx = SX; my = SY; mf = 0;
    end else begin
      if (single) mf = d;
      if (valid) begin mx = tx; my = ty; end
    end
  endtask

  // Scan a window around the sprite; the draw bit lags the pixel by one clock
  task automatic raster();
    int r, c, exp;
    for (int rr = my - 2; rr <= my + SZ + 1; rr++) begin
      for (int cc = mx - 2; cc <= mx + SZ + 1; cc++) begin
        col = 10'(cc); row = 10'(rr);
        r = rr - my; c = cc - mx;
        exp = 0;
        if (r >= 0 && r < SZ && c >= 0 && c < SZ) begin
          case (mf)
            0: exp = bmp[r][c];
            1: exp = bmp[SZ - 1 - r][c];
            2: exp = bmp[c][r];
            default: exp = bmp[c][SZ - 1 - r];
          endcase
        end
        @(posedge clk); #1;
        chk($sformatf("draw f%0d r%0d c%0d", mf, rr, cc), draw, exp);
      end
    end
  endtask

  initial begin
    logic [3:0] m;
    bmp[0] = 8'b0100_0110; bmp[1] = 8'b0111_1110; bmp[2] = 8'b1101_1001; bmp[3] = 8'b0111_1110;
    bmp[4] = 8'b0011_1100; bmp[5] = 8'b0111_1111; bmp[6] = 8'b1100_0011; bmp[7] = 8'b1000_0001;
    rst_l = 1'b0; en = 1'b1; resp = 1'b0; btn_v = 4'b0000; drive_btn();
    col = 10'd0; row = 10'd0;
    mx = SX; my = SY; mf = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset x", sx, SX);
    chk("reset y", sy, SY);
    chk("reset facing", fac, 0);
    chk("reset busy", busy, 0);
    chk("reset hop_done", done, 0);
    chk("reset draw", draw, 0);
    rst_l = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_press(4'b0001, 1, 0, 0);     // up: 40 -> 32
    run_press(4'b0010, 3, 0, 0);     // down back to 40
    run_press(4'b0010, 2, 0, 0);     // down at bottom edge: facing only
    run_press(4'b0001, 200, 1, 0);   // held up with extra press while busy
    run_press(4'b0101, 2, 0, 0);     // up+left together: ignored
    run_press(4'b0100, 2, 0, 0);     // left 28 -> 20
    run_press(4'b0100, 2, 0, 0);     // 20 -> 12
    run_press(4'b0100, 2, 0, 0);     // 12 -> 4
    run_press(4'b0100, 2, 0, 0);     // left at 4: blocked
    run_press(4'b0001, 3, 3, 0);     // respawn mid-hop
    run_press(4'b0001, 2, 2, 50);    // pause mid-hop
    raster();
    run_press(4'b0010, 2, 0, 0);     // facing down
    raster();
    run_press(4'b1000, 2, 0, 0);     // facing right
    raster();
    run_press(4'b0100, 2, 0, 0);     // facing left
    raster();

    for (int t = 0; t < 20; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        m = 4'($urandom_range(1, 15));
      end else begin
        m = 4'b0001 << $urandom_range(0, 3);
      end
      run_press(m, $urandom_range(1, 30), $urandom_range(0, 3), $urandom_range(1, 20));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
